// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer sitting on the CPU data-memory port
// behind the system bridge.
//
// Register window (16 bytes at BASE_ADDR, index = addr[3:2]):
//   0 CTRL   {28'b0, IM, MODE[1:0], EN}
//   1 PRESET reload value
//   2 COUNT  current count (read-only)
//   3 reserved (reads 0, writes ignored)
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   addr   byte address from the CPU M stage; bits [1:0] ignored
//   we     write strobe, one cycle per store
//   be     byte enables; be[i] covers wdata[8i+7:8i]
//   wdata  store data
//   rdata  combinational read data, decoded from addr[3:2] only
//   irq    interrupt request, IM & (irq_pend | irq_pulse)
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_pend;
  logic        irq_pulse, irq_pulse_nxt;
  logic        fsm_en_clr;
  logic        fsm_pend_set;

  logic        sel;
  logic [1:0]  idx;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        unused_addr_bits;

  assign sel              = (addr[31:4] == BASE_ADDR[31:4]);
  assign idx              = addr[3:2];
  assign wr_ctrl          = we & sel & (idx == 2'd0);
  assign wr_preset        = we & sel & (idx == 2'd1);
  assign unused_addr_bits = ^addr[1:0];

  // Only MODE==01 reloads; 10 and 11 fall back to one-shot.
  logic auto_reload;
  assign auto_reload = (mode == 2'b01);

  // Read path: purely combinational so a same-cycle read sees the pre-write value.
  always_comb begin
    rdata = 32'h0;
    case (idx)
      2'd0:    rdata = {28'h0, im, mode, en};
      2'd1:    rdata = preset;
      2'd2:    rdata = count;
      default: rdata = 32'h0;
    endcase
  end

  assign irq = im & (irq_pend | irq_pulse);

  // Next-state / datapath decisions for the countdown FSM.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    irq_pulse_nxt = 1'b0;
    fsm_en_clr    = 1'b0;
    fsm_pend_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = en ? S_CNT : S_IDLE;
      end
      S_CNT: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // PRESET of 0 or 1 both expire from here.
          count_nxt = 32'h0;
          state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          irq_pulse_nxt = 1'b1;
          state_nxt     = S_LOAD;
        end else begin
          fsm_en_clr   = 1'b1;
          fsm_pend_set = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= 32'h0;
      irq_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      irq_pulse <= irq_pulse_nxt;
    end
  end

  // CTRL: a CPU write to lane 0 overrides the one-shot auto-clear of EN.
  always_ff @(posedge clk) begin
    if (reset) begin
      en   <= 1'b0;
      mode <= 2'b00;
      im   <= 1'b0;
    end else if (wr_ctrl && be[0]) begin
      en   <= wdata[0];
      mode <= wdata[2:1];
      im   <= wdata[3];
    end else if (fsm_en_clr) begin
      en   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= 32'h0;
    end else if (wr_preset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Write-clear from a CTRL/PRESET store beats a same-cycle expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pend <= 1'b0;
    end else if (wr_ctrl || wr_preset) begin
      irq_pend <= 1'b0;
    end else if (fsm_pend_set) begin
      irq_pend <= 1'b1;
    end
  end

endmodule
